// File: rtl/cp0_timer.sv
// cp0_timer: MIPS coprocessor 0 (SR, Cause, EPC, PRId, Count/Compare) at the M/W commit point.
// Define CP0_TIMER_EN to build the Count/Compare timer; without it TI is tied low and no timer flops exist.
module cp0_timer #(
   parameter int          NUM_HWINT = 6,
   parameter logic [31:0] PRID_VAL  = 32'h11223344
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           rd_addr,
   output logic [31:0]          rd_data,
   input  logic                 wr_en,
   input  logic [4:0]           wr_addr,
   input  logic [31:0]          wr_data,
   input  logic [31:0]          pc,
   input  logic                 bd,
   input  logic                 exc_valid,
   input  logic [4:0]           exc_code,
   input  logic                 eret,
   input  logic [NUM_HWINT-1:0] hw_int,
   output logic                 int_req,
   output logic [31:0]          epc
);

   localparam logic [4:0] A_COUNT   = 5'd9;
   localparam logic [4:0] A_COMPARE = 5'd11;
   localparam logic [4:0] A_SR      = 5'd12;
   localparam logic [4:0] A_CAUSE   = 5'd13;
   localparam logic [4:0] A_EPC     = 5'd14;
   localparam logic [4:0] A_PRID    = 5'd15;

   logic [5:0]           r_im;
   logic                 r_exl;
   logic                 r_ie;
   logic                 r_bd;
   logic [4:0]           r_exc_code;
   logic [31:0]          r_epc;
   logic [NUM_HWINT-1:0] r_hw;

   logic        w_wr_sr;
   logic        w_wr_epc;
   logic [5:0]  w_im_eff;
   logic        w_ie_eff;
   logic        w_exl_eff;
   logic [5:0]  w_ip;
   logic [31:0] w_count;
   logic [31:0] w_compare;
   logic        w_ti;

   assign w_wr_sr  = wr_en && (wr_addr == A_SR);
   assign w_wr_epc = wr_en && (wr_addr == A_EPC);

`ifdef CP0_TIMER_EN
   logic        w_wr_count;
   logic        w_wr_compare;
   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic        r_ti;

   assign w_wr_count   = wr_en && (wr_addr == A_COUNT);
   assign w_wr_compare = wr_en && (wr_addr == A_COMPARE);

   // NOTE: sequential state uses <= so every flop samples pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count   <= '0;
         r_compare <= '1;
         r_ti      <= 1'b0;
      end else begin
         r_count <= w_wr_count ? wr_data : r_count + 32'd1;
         if (w_wr_compare) begin
            r_compare <= wr_data;
            r_ti      <= 1'b0;  // clear wins over a match on the same edge
         end else if (r_count == r_compare) begin
            r_ti <= 1'b1;
         end
      end
   end

   assign w_count   = r_count;
   assign w_compare = r_compare;
   assign w_ti      = r_ti;
`else
   assign w_count   = '0;
   assign w_compare = '0;
   assign w_ti      = 1'b0;
`endif

   // Interrupt decisions see an SR being written this cycle.
   assign w_im_eff  = w_wr_sr ? wr_data[15:10] : r_im;
   assign w_ie_eff  = w_wr_sr ? wr_data[0]     : r_ie;
   assign w_exl_eff = w_wr_sr ? wr_data[1]     : r_exl;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_ip = '0;
      for (int i = 0; i < NUM_HWINT; i++) begin
         w_ip[i] = r_hw[i];
      end
      w_ip[5] = w_ip[5] | w_ti;
   end

   assign int_req = !reset && !w_exl_eff &&
                    (exc_valid || (w_ie_eff && |(w_ip & w_im_eff)));

   assign epc = w_wr_epc ? wr_data : r_epc;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_im       <= '0;
         r_exl      <= 1'b0;
         r_ie       <= 1'b0;
         r_bd       <= 1'b0;
         r_exc_code <= '0;
         r_epc      <= '0;
         r_hw       <= '0;
      end else begin
         r_hw <= hw_int;
         if (w_wr_sr) begin
            r_im <= wr_data[15:10];
            r_ie <= wr_data[0];
         end
         // Exception entry beats eret, which beats the EXL value written by mtc0.
         if (int_req) begin
            r_exl <= 1'b1;
         end else if (eret) begin
            r_exl <= 1'b0;
         end else if (w_wr_sr) begin
            r_exl <= wr_data[1];
         end
         if (int_req) begin
            r_epc      <= bd ? pc - 32'd4 : pc;
            r_bd       <= bd;
            r_exc_code <= exc_valid ? exc_code : 5'd0;
         end else if (w_wr_epc) begin
            r_epc <= wr_data;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      case (rd_addr)
         A_COUNT:   rd_data = w_count;
         A_COMPARE: rd_data = w_compare;
         A_SR:      rd_data = {16'b0, r_im, 8'b0, r_exl, r_ie};
         A_CAUSE:   rd_data = {r_bd, w_ti, 14'b0, w_ip, 3'b0, r_exc_code, 2'b0};
         A_EPC:     rd_data = r_epc;
         A_PRID:    rd_data = PRID_VAL;
         default:   rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_timer.sv
// Self-checking bench for cp0_timer: directed test-plan steps, then randomized traffic against a register-level model.
module tb_cp0_timer;

   localparam int          NUM_HWINT = 6;
   localparam logic [31:0] PRID      = 32'h11223344;
   localparam logic [31:0] SR_MASK   = 32'h0000_FC03;
`ifdef CP0_TIMER_EN
   localparam bit TIMER_EN = 1'b1;
`else
   localparam bit TIMER_EN = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 reset;
   logic [4:0]           rd_addr;
   logic [31:0]          rd_data;
   logic                 wr_en;
   logic [4:0]           wr_addr;
   logic [31:0]          wr_data;
   logic [31:0]          pc;
   logic                 bd;
   logic                 exc_valid;
   logic [4:0]           exc_code;
   logic                 eret;
   logic [NUM_HWINT-1:0] hw_int;
   logic                 int_req;
   logic [31:0]          epc;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: architectural register contents.
   logic [31:0] m_sr, m_epc, m_count, m_compare;
   logic        m_bd, m_ti;
   logic [4:0]  m_exc;
   logic [5:0]  m_hw;

   cp0_timer #(.NUM_HWINT(NUM_HWINT), .PRID_VAL(PRID)) dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pc(pc), .bd(bd),
      .exc_valid(exc_valid), .exc_code(exc_code), .eret(eret), .hw_int(hw_int),
      .int_req(int_req), .epc(epc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_sr = '0; m_epc = '0; m_count = '0; m_compare = '1;
      m_bd = 1'b0; m_ti = 1'b0; m_exc = '0; m_hw = '0;
   endtask

   function automatic logic [5:0] m_ip();
      logic [5:0] ip;
      ip = m_hw & 6'((1 << NUM_HWINT) - 1);
      if (m_ti) ip = ip | 6'b10_0000;
      return ip;
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      case (a)
         5'd9:    return TIMER_EN ? m_count : 32'd0;
         5'd11:   return TIMER_EN ? m_compare : 32'd0;
         5'd12:   return m_sr;
         5'd13:   return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 10) | (32'(m_exc) << 2);
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic exp_int_req();
      logic [31:0] sr_eff;
      sr_eff = (wr_en && wr_addr == 5'd12) ? (wr_data & SR_MASK) : m_sr;
      if (reset || sr_eff[1]) return 1'b0;
      return exc_valid || (sr_eff[0] && ((m_ip() & sr_eff[15:10]) != 6'd0));
   endfunction

   task automatic model_update(input logic ireq);
      logic [31:0] sr_next;
      logic        match;
      if (reset) begin
         model_reset();
         return;
      end
      sr_next = m_sr;
      if (wr_en && wr_addr == 5'd12) sr_next = wr_data & SR_MASK;
      if (eret) sr_next = sr_next & ~32'd2;
      if (ireq) sr_next = sr_next | 32'd2;
      m_sr = sr_next;
      if (ireq) begin
         m_epc = bd ? pc - 32'd4 : pc;
         m_bd  = bd;
         m_exc = exc_valid ? exc_code : 5'd0;
      end else if (wr_en && wr_addr == 5'd14) begin
         m_epc = wr_data;
      end
      if (TIMER_EN) begin
         match   = (m_count == m_compare);
         m_count = (wr_en && wr_addr == 5'd9) ? wr_data : m_count + 32'd1;
         if (wr_en && wr_addr == 5'd11) begin
            m_compare = wr_data;
            m_ti      = 1'b0;
         end else if (match) begin
            m_ti = 1'b1;
         end
      end
      m_hw = 6'(hw_int);
   endtask

   task automatic idle();
      reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; pc = '0; bd = 1'b0;
      exc_valid = 1'b0; exc_code = '0; eret = 1'b0;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Compare outputs against the model, then advance one edge.
   task automatic finish_cycle();
      logic ireq;
      ireq = exp_int_req();
      check("int_req", 32'(int_req), 32'(ireq));
      check($sformatf("rd_data[%0d]", rd_addr), rd_data, exp_read(rd_addr));
      check("epc_port", epc, (wr_en && wr_addr == 5'd14) ? wr_data : m_epc);
      @(posedge clk);
      model_update(ireq);
      #1;
   endtask

   task automatic step();
      settle();
      finish_cycle();
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      idle(); wr_en = 1'b1; wr_addr = a; wr_data = d;
      step();
      idle();
   endtask

   initial begin
      logic [4:0]  addr_tbl [7] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
      logic [31:0] v;
      int          seen;

      idle();
      hw_int  = '0;
      rd_addr = '0;
      reset   = 1'b1;
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      reset = 1'b0;

      // Reset state of every register.
      foreach (addr_tbl[i]) begin
         rd_addr = addr_tbl[i];
         step();
      end
      rd_addr = 5'd15; settle(); check("prid", rd_data, 32'h11223344); finish_cycle();
      rd_addr = 5'd11; settle(); check("compare_rst", rd_data, TIMER_EN ? 32'hFFFF_FFFF : 32'd0); finish_cycle();

      // Hardware interrupt 0 through SR.IM[10] and IE.
      hw_int = 6'b00_0001;
      mtc0(5'd12, 32'h0000_0401);
      pc = 32'h3000; bd = 1'b0;
      settle(); check("hw_irq", 32'(int_req), 32'd1); finish_cycle();
      idle();
      rd_addr = 5'd14; settle(); check("epc_hw", rd_data, 32'h3000); check("irq_exl", 32'(int_req), 32'd0); finish_cycle();
      rd_addr = 5'd12; settle(); check("sr_exl", rd_data, 32'h0000_0403); finish_cycle();
      rd_addr = 5'd13; settle(); check("cause_hw", rd_data, 32'h0000_0400); finish_cycle();
      hw_int = '0;
      step();

      // Synchronous exception in a delay slot with IE = 0.
      eret = 1'b1; step(); idle();
      mtc0(5'd12, 32'h0);
      exc_valid = 1'b1; exc_code = 5'd4; bd = 1'b1; pc = 32'h3008;
      settle(); check("exc_irq", 32'(int_req), 32'd1); finish_cycle();
      idle();
      rd_addr = 5'd14; settle(); check("epc_bd", rd_data, 32'h3004); finish_cycle();
      rd_addr = 5'd13; settle(); check("cause_exc", rd_data, 32'h8000_0010); finish_cycle();

      // eret together with an exception: the exception wins.
      eret = 1'b1; step(); idle();
      eret = 1'b1; exc_valid = 1'b1; exc_code = 5'd8; pc = 32'h5000;
      step(); idle();
      rd_addr = 5'd12; settle(); check("eret_vs_exc", rd_data, 32'h0000_0002); finish_cycle();
      rd_addr = 5'd14; settle(); check("epc_exc2", rd_data, 32'h5000); finish_cycle();
      wr_en = 1'b1; wr_addr = 5'd14; wr_data = 32'h4000;
      settle(); check("epc_fwd", epc, 32'h4000); finish_cycle();
      idle();
      settle(); check("epc_written", rd_data, 32'h4000); finish_cycle();

      // Timer interrupt through IM[15].
      eret = 1'b1; step(); idle();
      mtc0(5'd12, 32'h0000_8001);
      mtc0(5'd9, 32'd0);
      mtc0(5'd11, 32'd10);
      seen = 0;
      rd_addr = 5'd13;
      for (int i = 0; i < 30; i++) begin
         settle();
         if (int_req) seen++;
         finish_cycle();
      end
      check("timer_irq", 32'(seen), 32'(TIMER_EN));
      settle(); v = rd_data; check("ti_set", 32'(v[30]), 32'(TIMER_EN)); finish_cycle();
      mtc0(5'd11, 32'h1000);
      settle(); v = rd_data; check("ti_clear", 32'(v[30]), 32'd0); finish_cycle();

      // Count wrap.
      mtc0(5'd9, 32'hFFFF_FFFF);
      rd_addr = 5'd9; step();
      settle(); check("count_wrap", rd_data, 32'd0); finish_cycle();

      // Reset while EXL is set.
      exc_valid = 1'b1; exc_code = 5'd12; pc = 32'h6000; step(); idle();
      rd_addr = 5'd12; settle(); v = rd_data; check("exl_before_rst", 32'(v[1]), 32'd1); finish_cycle();
      reset = 1'b1; step(); reset = 1'b0;
      settle(); check("sr_after_rst", rd_data, 32'd0); finish_cycle();
      rd_addr = 5'd14; settle(); check("epc_after_rst", rd_data, 32'd0); finish_cycle();
      rd_addr = 5'd13; settle(); check("cause_after_rst", rd_data, 32'd0); finish_cycle();

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         idle();
         v       = $urandom;
         rd_addr = addr_tbl[$urandom_range(0, 6)];
         if ($urandom_range(0, 7) == 0) hw_int = v[NUM_HWINT-1:0];
         if ($urandom_range(0, 3) == 0) begin
            wr_en   = 1'b1;
            wr_addr = addr_tbl[$urandom_range(0, 6)];
            wr_data = $urandom;
            if (wr_addr == 5'd11 && v[31]) wr_data = m_count + $urandom_range(2, 30);
         end
         pc        = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         bd        = v[8];
         exc_valid = ($urandom_range(0, 7) == 0);
         exc_code  = v[20:16];
         eret      = ($urandom_range(0, 7) == 0);
         reset     = ($urandom_range(0, 199) == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cp0_timer.md
# cp0_timer

Parametrised coprocessor-0 for the pipelined MIPS core, sitting beside the M/W stage boundary where exceptions are committed. Holds SR, Cause, EPC, PRId and a Count/Compare timer. Takes a configurable number of external hardware interrupt lines plus an internal timer interrupt. Raises a single exception/interrupt request and provides the EPC for `eret`.

## Interface
- `NUM_HWINT`, 6: external interrupt lines, 1..6; line i maps to Cause.IP bit 10+i.
- `PRID_VAL`, 32'h11223344: constant value returned by PRId.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `rd_addr` in 5: mfc0 register number.
- `rd_data` out 32: combinational read data.
- `wr_en` in 1: mtc0 write enable.
- `wr_addr` in 5: mtc0 register number.
- `wr_data` in 32: mtc0 data.
- `pc` in 32: PC of the instruction being committed.
- `bd` in 1: committed instruction is in a branch delay slot.
- `exc_valid` in 1: synchronous exception present.
- `exc_code` in 5: code of that exception.
- `eret` in 1: eret commits this cycle.
- `hw_int` in NUM_HWINT: level-sensitive external interrupts.
- `int_req` out 1: take the exception vector this cycle.
- `epc` out 32: EPC, forwarded.

## Operation
- Register map:
  - 9 = Count
  - 11 = Compare
  - 12 = SR: IM[15:10], EXL[1], IE[0]; other bits read 0.
  - 13 = Cause: BD[31], TI[30], IP[15:10], ExcCode[6:2].
  - 14 = EPC
  - 15 = PRId
  - Any other address reads 0; writes to it are ignored.
- Cause.IP:
  - IP[10+i] is hw_int[i], registered every edge.
  - IP[15] is the timer pending bit TI; Cause[30] mirrors TI.
  - NUM_HWINT < 6 leaves the unused IP bits at 0.
  - When NUM_HWINT = 6, IP[15] = hw_int[5] | TI.
- Effective SR is wr_data when wr_en && wr_addr==12, else SR.
- int_req = !reset && !EXL_eff && (exc_valid || (IE_eff && |(IP & IM_eff))).
- On an edge with int_req:
  - EXL <= 1
  - EPC <= bd ? pc-4 : pc
  - BD <= bd
  - ExcCode <= exc_valid ? exc_code : 0
- exc_valid has priority over interrupts for ExcCode.
- Same-cycle mtc0 SR with int_req: SR takes wr_data, except EXL, which is 1.
- Same-cycle mtc0 EPC with int_req: hardware EPC wins.
- eret: EXL <= 0 on the edge. If int_req is also high, int_req wins.
- epc output = wr_data when mtc0 EPC this cycle, else the EPC register.
- Timer:
  - Count increments by 1 every cycle and wraps 0xFFFFFFFF -> 0.
  - mtc0 Count loads wr_data; no increment that cycle.
  - When Count == Compare on an edge, TI <= 1. TI is sticky.
  - mtc0 Compare loads the value and clears TI. Clear beats a same-edge set.
- Reset values:
  - SR, Cause, EPC, Count = 0
  - Compare = 32'hFFFFFFFF
  - TI = 0
  - int_req = 0
  - epc = 0

## Timing
- mfc0 reads are combinational and return register contents before this edge's update. No internal bypass except SR (for int_req) and EPC (for the epc port).
- hw_int to IP: 1-cycle latency. A line asserted before edge n is visible in Cause and int_req after edge n.
- Timer: Count == Compare at edge n gives TI = 1 after edge n. int_req can rise in the following cycle.
- Writes take effect at the edge; a read in the next cycle returns the new value.
- Reset mid-operation clears all state on the next edge, including a pending TI and EXL.

## Configuration
- `CP0_TIMER_EN` defined: Count/Compare/TI are implemented as above.
- `CP0_TIMER_EN` undefined:
  - Count and Compare read 0 and writes to them are ignored.
  - TI is tied to 0 and IP[15] carries only hw_int[5], if present.
  - No timer flops are synthesised.

## Test plan
- Reset, then read all registers -> SR = Cause = EPC = Count = 0, Compare = FFFFFFFF, PRId = 11223344, int_req = 0.
- Write SR = 0x0000_0401, assert hw_int[0] -> int_req high one cycle later. Edge with pc = 0x3000, bd = 0 -> EPC = 0x3000, EXL = 1, ExcCode = 0, int_req low.
- exc_valid = 1, exc_code = 5'd4, bd = 1, pc = 0x3008 with SR.IE = 0 -> int_req = 1. After the edge, EPC = 0x3004 and Cause = 0x8000_0010.
- Write Compare = 10 with Count = 0 and SR = 0x8001 -> TI sets when Count reaches 10 and int_req follows. Writing Compare clears TI and Cause[30]. With CP0_TIMER_EN undefined, no interrupt occurs.
- Same cycle: eret and exc_valid -> EXL stays 1 and EPC is updated. Same cycle: mtc0 EPC = 0x4000, no exception -> epc port shows 0x4000 immediately.
- Write Count = FFFFFFFF -> reads 0 two cycles later (wrap). Assert reset during EXL = 1 -> all registers return to reset values.
